// File: rtl/key_debounce_event.sv
// key_debounce_event: conditions a raw active-low push-button pin.
// Synchronises the pin, debounces it with a counter-based FSM and produces a
// clean pressed level, one-cycle press/release strobes and a sticky event flag
// that software clears.
module key_debounce_event #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 20
) (
   input  logic clk,
   input  logic reset_n,
   input  logic key_n_raw,
   input  logic clear_event,
   output logic key_down,
   output logic press_pulse,
   output logic release_pulse,
   output logic event_pending
);

   typedef enum logic [1:0] {
      ST_RELEASED,
      ST_PRESS_CHK,
      ST_PRESSED,
      ST_RELEASE_CHK
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_s;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [CNT_W-1:0]       r_cnt;
   logic [CNT_W-1:0]       w_cnt_nxt;
   logic                   r_key_down;
   logic                   w_key_down_nxt;
   logic                   r_press;
   logic                   w_press_nxt;
   logic                   r_release;
   logic                   w_release_nxt;
   logic                   r_event;
   logic                   w_event_nxt;

   // Synchroniser chain; resets to the released (high) pin level.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync <= '1;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], key_n_raw};
      end
   end

   assign w_s = r_sync[SYNC_STAGES-1];

   // State, counter and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= ST_RELEASED;
         r_cnt      <= '0;
         r_key_down <= 1'b0;
         r_press    <= 1'b0;
         r_release  <= 1'b0;
         r_event    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_key_down <= w_key_down_nxt;
         r_press    <= w_press_nxt;
         r_release  <= w_release_nxt;
         r_event    <= w_event_nxt;
      end
   end

   // Next-state, counter and output decode; any opposite sample restarts the window.
   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_key_down_nxt = r_key_down;
      w_press_nxt    = 1'b0;
      w_release_nxt  = 1'b0;

      case (r_state)
         ST_RELEASED: begin
            if (!w_s) begin
               w_state_nxt = ST_PRESS_CHK;
               w_cnt_nxt   = '0;
            end
         end
         ST_PRESS_CHK: begin
            if (w_s) begin
               w_state_nxt = ST_RELEASED;
               w_cnt_nxt   = '0;
            end else if (r_cnt == CNT_LAST) begin
               w_state_nxt    = ST_PRESSED;
               w_cnt_nxt      = '0;
               w_key_down_nxt = 1'b1;
               w_press_nxt    = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         ST_PRESSED: begin
            if (w_s) begin
               w_state_nxt = ST_RELEASE_CHK;
               w_cnt_nxt   = '0;
            end
         end
         ST_RELEASE_CHK: begin
            if (!w_s) begin
               w_state_nxt = ST_PRESSED;
               w_cnt_nxt   = '0;
            end else if (r_cnt == CNT_LAST) begin
               w_state_nxt    = ST_RELEASED;
               w_cnt_nxt      = '0;
               w_key_down_nxt = 1'b0;
               w_release_nxt  = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_RELEASED;
            w_cnt_nxt   = '0;
         end
      endcase

      // Set beats clear on the same edge so a press is never lost.
      w_event_nxt = r_event;
      if (w_press_nxt) begin
         w_event_nxt = 1'b1;
      end else if (clear_event) begin
         w_event_nxt = 1'b0;
      end
   end

   assign key_down      = r_key_down;
   assign press_pulse   = r_press;
   assign release_pulse = r_release;
   assign event_pending = r_event;

endmodule

// File: tb/tb_key_debounce_event.sv
// Bench for key_debounce_event: directed scenarios followed by random pin
// activity, every output compared each cycle with a behavioural model.
module tb_key_debounce_event;

   localparam int SYNC = 2;
   localparam int DC   = 4;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic key_n_raw = 1'b1;
   logic clear_event = 1'b0;
   logic key_down;
   logic press_pulse;
   logic release_pulse;
   logic event_pending;

   int errors = 0;
   int checks = 0;

   // Model: pin samples not yet seen by the FSM, debounced level, run length
   // of consecutive samples opposing that level, and expected outputs.
   logic q[$];
   logic m_kd, m_pp, m_rp, m_ev;
   int   run;
   int   n_press, n_release;

   key_debounce_event #(
      .SYNC_STAGES     (SYNC),
      .DEBOUNCE_CYCLES (DC),
      .CNT_W           (3)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .key_n_raw     (key_n_raw),
      .clear_event   (clear_event),
      .key_down      (key_down),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .event_pending (event_pending)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      for (int i = 0; i < SYNC; i++) q.push_back(1'b1);
      m_kd = 1'b0; m_pp = 1'b0; m_rp = 1'b0; m_ev = 1'b0;
      run = 0;
   endtask

   task automatic check_all(input string tag);
      chk({tag, "_kd"}, key_down, m_kd);
      chk({tag, "_pp"}, press_pulse, m_pp);
      chk({tag, "_rp"}, release_pulse, m_rp);
      chk({tag, "_ev"}, event_pending, m_ev);
   endtask

   // One clock: drive inputs, advance the model on the edge, compare #1 later.
   task automatic step(input logic pin, input logic clr, input string tag);
      logic x;
      key_n_raw   = pin;
      clear_event = clr;
      @(posedge clk);
      x = q.pop_front();
      q.push_back(pin);
      m_pp = 1'b0;
      m_rp = 1'b0;
      // A pin sample opposing the level is 0 when released and 1 when pressed.
      if (x == m_kd) run++;
      else run = 0;
      if (run == DC + 1) begin
         m_kd = ~m_kd;
         if (m_kd) m_pp = 1'b1;
         else m_rp = 1'b1;
         run = 0;
      end
      if (m_pp) m_ev = 1'b1;
      else if (clr) m_ev = 1'b0;
      #1;
      if (press_pulse === 1'b1) n_press++;
      if (release_pulse === 1'b1) n_release++;
      check_all(tag);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      model_reset();
      check_all("rst_now");
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      int len;
      logic lvl;

      model_reset();
      n_press = 0;
      n_release = 0;
      #2;
      check_all("reset");
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;

      // 1: clean press, accepted on edge 6
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 1'b0, "t1");
         chk("t1_pp_early", press_pulse, 1'b0);
      end
      step(1'b0, 1'b0, "t1_e6");
      chk("t1_kd_e6", key_down, 1'b1);
      chk("t1_pp_e6", press_pulse, 1'b1);
      chk("t1_ev_e6", event_pending, 1'b1);
      step(1'b0, 1'b0, "t1_e7");
      chk("t1_pp_e7", press_pulse, 1'b0);

      // 3: clean release, event stays set
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, "t3");
      step(1'b1, 1'b0, "t3_e6");
      chk("t3_kd_e6", key_down, 1'b0);
      chk("t3_rp_e6", release_pulse, 1'b1);
      chk("t3_ev_e6", event_pending, 1'b1);
      step(1'b1, 1'b1, "clr");
      chk("clr_ev", event_pending, 1'b0);

      // 2: bounce rejected
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "t2");
      step(1'b1, 1'b0, "t2");
      for (int i = 0; i < 2; i++) step(1'b0, 1'b0, "t2");
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 1'b0, "t2");
         chk("t2_kd", key_down, 1'b0);
         chk("t2_ev", event_pending, 1'b0);
      end

      // 4: clear on the press edge loses to the set; later clear works
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, "t4");
      step(1'b0, 1'b1, "t4_race");
      chk("t4_race_pp", press_pulse, 1'b1);
      chk("t4_race_ev", event_pending, 1'b1);
      step(1'b0, 1'b1, "t4_clr");
      chk("t4_clr_ev", event_pending, 1'b0);
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, "t4_rel");

      // 5: reset in PRESS_CHK with cnt=2, then full re-debounce
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, "t5");
      n_release = 0;
      do_reset();
      chk("t5_kd_rst", key_down, 1'b0);
      n_press = 0;
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, "t5_post");
      step(1'b0, 1'b0, "t5_e6");
      chk("t5_pp_e6", press_pulse, 1'b1);

      // 6: long hold yields a single press, no release
      for (int i = 0; i < 100; i++) step(1'b0, 1'b0, "t6");
      chk("t6_one_press", 1'(n_press == 1), 1'b1);
      chk("t6_no_release", 1'(n_release == 0), 1'b1);
      chk("t6_kd", key_down, 1'b1);

      // Random pin runs (many shorter than the window) and random clears
      lvl = 1'b0;
      for (int r = 0; r < 120; r++) begin
         lvl = ~lvl;
         len = $urandom_range(1, 9);
         for (int i = 0; i < len; i++)
            step(lvl, 1'($urandom_range(0, 7) == 0), "rnd");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Time bound on the whole run.
   initial begin
      #200000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
